regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
Parametrised successor to the processor's 2-read/1-write register file. Adds:
- configurable data width and depth
- byte-masked writes
- a hardwired-zero option for register 0
- a multi-cycle sequential clear engine with a busy flag, so software or the control unit can scrub the file without asserting the global reset

Sits in the datapath between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is an ordinary register.

Ports:
Clock      input   1          rising-edge clock
Reset      input   1          asynchronous, active-low (0 = reset)
ReadAddr1  input   ADDR_W     read port 1 address
ReadAddr2  input   ADDR_W     read port 2 address
ReadData1  output  DATA_W     read port 1 data
ReadData2  output  DATA_W     read port 2 data
WriteAddr  input   ADDR_W     write address
WriteData  input   DATA_W     write data
WriteMask  input   DATA_W/8   byte enables; bit i covers bits [8i+7:8i]
RegWrite   input   1          write enable
ClearReq   input   1          start a sequential clear (level-sampled)
ClearBusy  output  1          clear in progress

Behaviour:
- Reset = 0, asynchronously: all DEPTH registers set to 0, FSM forced to IDLE, clear index set to 0, ClearBusy = 0. Effect is immediate, with no clock required.
- Reads are combinational.
  - ReadDataN = reg[ReadAddrN], except it is forced to 0 when ZERO_REG = 1 and ReadAddrN = 0.
  - Both ports may read the same address simultaneously.
- Writes:
  - On a rising edge with RegWrite = 1 in state IDLE, each byte i with WriteMask[i] = 1 is updated from WriteData.
  - Unmasked bytes keep their value.
  - WriteMask = 0 gives no change.
  - Write to address 0 with ZERO_REG = 1 is discarded.
- Without the bypass feature, a read of the address being written returns the old value until the edge.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on a rising edge with ClearReq = 1. On that edge the clear index is set to 0. Any RegWrite in the same cycle is performed first (it is accepted, then cleared later).
  - CLEAR: on each edge, reg[index] <= 0 and index increments. 1 register per cycle.
  - CLEAR -> IDLE on the edge that clears index DEPTH-1; the index wraps to 0.
  - ClearBusy = 1 exactly while in CLEAR, i.e. for DEPTH cycles. Clear of 32 registers takes 32 cycles.
- During CLEAR:
  - RegWrite is ignored, with no queuing. The writer must hold off while ClearBusy = 1.
  - ClearReq is ignored; a clear is not restarted.
  - Reads return current array contents. Registers at or above the current index still hold their old values.
- ClearReq still high when returning to IDLE starts a new clear on the next edge. Callers pulse it for one cycle.
- Reset = 0 mid-clear aborts the clear: all registers are 0 and the FSM is in IDLE.
- No X on any output after reset; registers are never left uninitialised.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If RegWrite = 1, FSM is in IDLE, and ReadAddrN = WriteAddr (and not the zero register when ZERO_REG = 1), then ReadDataN combinationally returns the byte-merged value: WriteData bytes where WriteMask = 1, stored bytes elsewhere. Applies to both ports independently.
- Undefined: no forwarding. The read returns the pre-edge value, as in the previous generation.

Test Plan:
1. Reset = 0 for 10 ns, then 1. Read addresses 1 and 31 -> 0x00000000 on both ports, ClearBusy = 0.
2. Write 0xA5A5A5A5 to r1 with WriteMask = 4'hF, then WriteMask = 4'b0010 with WriteData 0x0000FF00 -> r1 reads 0xA5A5FFA5. ReadAddr1 = ReadAddr2 = 1 gives equal outputs.
3. Write 0xDEADBEEF to r0 -> r0 reads 0x00000000 (ZERO_REG = 1). Rerun with ZERO_REG = 0 -> reads 0xDEADBEEF.
4. Fill r1..r31 with their index, then pulse ClearReq for 1 cycle.
   - ClearBusy is high for exactly 32 cycles.
   - After 5 cycles, r3 = 0 and r10 = 10.
   - A write of 0x12345678 to r20 during CLEAR has no effect, so r20 = 0 at the end.
   - Then all registers are 0.
5. Start a clear, assert Reset = 0 at cycle 7 -> ClearBusy drops immediately and all registers are 0. After Reset = 1, a write to r2 works on the next edge.
6. With REGFILE_BYPASS_EN: write 0xCAFEBABE to r4 with ReadAddr1 = 4 -> ReadData1 = 0xCAFEBABE before the edge. Without the macro -> the old value before the edge, 0xCAFEBABE after it.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: parametrised 2-read / 1-write register file with byte-masked
// writes, optional hardwired-zero register 0 and a sequential clear engine
// that scrubs one register per cycle while ClearBusy is high.
// Optional feature: define REGFILE_BYPASS_EN to forward an in-flight write
// (byte-merged) to either read port in the same cycle.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [ADDR_W-1:0]   ReadAddr1,
  input  logic [ADDR_W-1:0]   ReadAddr2,
  output logic [DATA_W-1:0]   ReadData1,
  output logic [DATA_W-1:0]   ReadData2,
  input  logic [ADDR_W-1:0]   WriteAddr,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic [DATA_W/8-1:0] WriteMask,
  input  logic                RegWrite,
  input  logic                ClearReq,
  output logic                ClearBusy
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int NBYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  if ((DATA_W % 8) != 0) begin : gDataWCheck
    $error("regfile_param: DATA_W must be a multiple of 8");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } stateT;

  stateT               state;
  stateT               nextState;
  logic [ADDR_W-1:0]   clearIdx;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic                writeAccept;

  // Replace the bytes of oldVal selected by mask with the bytes of newVal.
  function automatic logic [DATA_W-1:0] mergeBytes(
    input logic [DATA_W-1:0] oldVal,
    input logic [DATA_W-1:0] newVal,
    input logic [NBYTES-1:0] mask
  );
    logic [DATA_W-1:0] merged;
    merged = oldVal;
    for (int i = 0; i < NBYTES; i++) begin
      if (mask[i]) merged[8*i +: 8] = newVal[8*i +: 8];
    end
    return merged;
  endfunction

  // True when addr names the hardwired-zero register.
  function automatic logic isZeroReg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // A write lands only in IDLE and never on the hardwired-zero register.
  always_comb begin
    writeAccept = RegWrite && (state == IDLE) && !isZeroReg(WriteAddr);
  end

  // FSM state register and clear index; reset aborts any clear in progress.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      clearIdx <= '0;
    end else begin
      state <= nextState;
      if (state == CLEAR) begin
        clearIdx <= clearIdx + 1'b1;  // wraps to 0 after LAST_IDX
      end else if (ClearReq) begin
        clearIdx <= '0;
      end
    end
  end

  // Next-state logic: start a clear on request, leave after the last register.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (ClearReq) nextState = CLEAR;
      CLEAR:   if (clearIdx == LAST_IDX) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Register array: async reset, one-register-per-cycle clear, masked write.
  // NOTE: the array is reset explicitly because no read may ever return X;
  // this costs a reset net on every storage flop instead of a RAM macro.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[clearIdx] <= '0;
    end else if (writeAccept) begin
      regs[WriteAddr] <= mergeBytes(regs[WriteAddr], WriteData, WriteMask);
    end
  end

  // Combinational read ports with zero-register masking and optional bypass.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    ReadData1 = regs[ReadAddr1];
    ReadData2 = regs[ReadAddr2];
`ifdef REGFILE_BYPASS_EN
    if (writeAccept && (ReadAddr1 == WriteAddr))
      ReadData1 = mergeBytes(regs[ReadAddr1], WriteData, WriteMask);
    if (writeAccept && (ReadAddr2 == WriteAddr))
      ReadData2 = mergeBytes(regs[ReadAddr2], WriteData, WriteMask);
`else
    // Without forwarding a same-cycle read sees the pre-edge contents.
`endif
    if (isZeroReg(ReadAddr1)) ReadData1 = '0;
    if (isZeroReg(ReadAddr2)) ReadData2 = '0;
  end

  // Busy flag mirrors the CLEAR state directly.
  always_comb begin
    ClearBusy = (state == CLEAR);
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: stimulus pushes expected values, a
// monitor on the falling clock edge pops and compares them.
// A second instance with ZERO_REG = 0 shares all inputs.
module tb_regfile_param;

  localparam int SEL_RD1   = 0;
  localparam int SEL_RD2   = 1;
  localparam int SEL_BUSY  = 2;
  localparam int SEL_RD1_Z = 3;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [4:0]  ReadAddr1, ReadAddr2, WriteAddr;
  logic [31:0] WriteData;
  logic [3:0]  WriteMask;
  logic        RegWrite, ClearReq;
  logic [31:0] ReadData1, ReadData2, ReadData1Z, ReadData2Z;
  logic        ClearBusy, ClearBusyZ;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } sbEntry;

  sbEntry sbQ[$];
  int assertCount = 0;
  int failCount   = 0;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteAddr(WriteAddr), .WriteData(WriteData), .WriteMask(WriteMask),
    .RegWrite(RegWrite), .ClearReq(ClearReq), .ClearBusy(ClearBusy)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dutZ (
    .Clock(Clock), .Reset(Reset),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(ReadData1Z), .ReadData2(ReadData2Z),
    .WriteAddr(WriteAddr), .WriteData(WriteData), .WriteMask(WriteMask),
    .RegWrite(RegWrite), .ClearReq(ClearReq), .ClearBusy(ClearBusyZ)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expectVal(input string name, input int sel, input logic [31:0] exp);
    sbEntry e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sbQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic writeReg(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] mask);
    WriteAddr = addr;
    WriteData = data;
    WriteMask = mask;
    RegWrite  = 1'b1;
    tick();
    RegWrite  = 1'b0;
  endtask

  // Monitor: drain every pending expectation against the settled outputs.
  always @(negedge Clock) begin
    sbEntry      e;
    logic [31:0] act;
    while (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      case (e.sel)
        SEL_RD1:   act = ReadData1;
        SEL_RD2:   act = ReadData2;
        SEL_BUSY:  act = {31'd0, ClearBusy};
        SEL_RD1_Z: act = ReadData1Z;
        default:   act = 'x;
      endcase
      check(e.name, act, e.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b0; ReadAddr1 = '0; ReadAddr2 = '0; WriteAddr = '0;
    WriteData = '0; WriteMask = '0; RegWrite = 1'b0; ClearReq = 1'b0;
    #10;
    Reset = 1'b1;
    tick();

    // 1: reset state
    ReadAddr1 = 5'd1; ReadAddr2 = 5'd31;
    expectVal("reset r1", SEL_RD1, 32'h0);
    expectVal("reset r31", SEL_RD2, 32'h0);
    expectVal("reset busy", SEL_BUSY, 32'h0);
    tick();

    // 2: full and byte-masked writes, mask 0 leaves value unchanged
    writeReg(5'd1, 32'hA5A5_A5A5, 4'hF);
    ReadAddr1 = 5'd1; ReadAddr2 = 5'd1;
    expectVal("full write r1", SEL_RD1, 32'hA5A5_A5A5);
    writeReg(5'd1, 32'h0000_FF00, 4'b0010);
    expectVal("masked write p1", SEL_RD1, 32'hA5A5_FFA5);
    expectVal("masked write p2", SEL_RD2, 32'hA5A5_FFA5);
    writeReg(5'd1, 32'hFFFF_FFFF, 4'h0);
    expectVal("mask zero no change", SEL_RD1, 32'hA5A5_FFA5);
    tick();

    // 3: register 0 hardwired vs ordinary
    writeReg(5'd0, 32'hDEAD_BEEF, 4'hF);
    ReadAddr1 = 5'd0;
    expectVal("r0 zero_reg=1", SEL_RD1, 32'h0);
    expectVal("r0 zero_reg=0", SEL_RD1_Z, 32'hDEAD_BEEF);
    tick();

    // 4: fill, then sequential clear
    for (int i = 1; i < 32; i++) writeReg(5'(i), 32'(i), 4'hF);
    ReadAddr1 = 5'd1; ReadAddr2 = 5'd31;
    expectVal("fill r1", SEL_RD1, 32'd1);
    expectVal("fill r31", SEL_RD2, 32'd31);
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    for (int k = 0; k < 32; k++) begin
      expectVal($sformatf("busy cyc%0d", k), SEL_BUSY, 32'h1);
      if (k == 5) begin
        ReadAddr1 = 5'd3; ReadAddr2 = 5'd10;
        expectVal("mid-clear r3", SEL_RD1, 32'h0);
        expectVal("mid-clear r10", SEL_RD2, 32'd10);
      end
      if (k == 25) begin
        ReadAddr2 = 5'd31;
        expectVal("mid-clear r31", SEL_RD2, 32'd31);
        WriteAddr = 5'd20; WriteData = 32'h1234_5678; WriteMask = 4'hF;
        RegWrite = 1'b1;
      end
      if (k == 26) RegWrite = 1'b0;
      tick();
    end
    expectVal("busy after clear", SEL_BUSY, 32'h0);
    ReadAddr1 = 5'd20;
    expectVal("write during clear ignored", SEL_RD1, 32'h0);
    tick();
    for (int a = 0; a < 32; a += 2) begin
      ReadAddr1 = 5'(a); ReadAddr2 = 5'(a + 1);
      expectVal($sformatf("cleared r%0d", a), SEL_RD1, 32'h0);
      expectVal($sformatf("cleared r%0d", a + 1), SEL_RD2, 32'h0);
      expectVal($sformatf("cleared z r%0d", a), SEL_RD1_Z, 32'h0);
      tick();
    end

    // 5: reset aborts a clear
    writeReg(5'd5, 32'h0000_0055, 4'hF);
    writeReg(5'd30, 32'h3030_3030, 4'hF);
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    repeat (7) tick();
    #2;
    Reset = 1'b0;
    ReadAddr1 = 5'd30; ReadAddr2 = 5'd5;
    expectVal("abort busy", SEL_BUSY, 32'h0);
    expectVal("abort r30", SEL_RD1, 32'h0);
    expectVal("abort r5", SEL_RD2, 32'h0);
    tick();
    Reset = 1'b1;
    writeReg(5'd2, 32'h2222_2222, 4'hF);
    ReadAddr1 = 5'd2; ReadAddr2 = 5'd30;
    expectVal("post-reset write r2", SEL_RD1, 32'h2222_2222);
    expectVal("post-reset r30", SEL_RD2, 32'h0);
    expectVal("post-reset busy", SEL_BUSY, 32'h0);
    tick();

    // 6: same-cycle read of the write address
    ReadAddr1 = 5'd4; ReadAddr2 = 5'd4;
    WriteAddr = 5'd4; WriteData = 32'hCAFE_BABE; WriteMask = 4'hF; RegWrite = 1'b1;
`ifdef REGFILE_BYPASS_EN
    expectVal("pre-edge r4", SEL_RD1, 32'hCAFE_BABE);
`else
    expectVal("pre-edge r4", SEL_RD1, 32'h0);
`endif
    tick();
    RegWrite = 1'b0;
    expectVal("post-edge r4", SEL_RD1, 32'hCAFE_BABE);
    tick();
    WriteData = 32'h0000_00FF; WriteMask = 4'b0001; RegWrite = 1'b1;
`ifdef REGFILE_BYPASS_EN
    expectVal("pre-edge masked r4", SEL_RD2, 32'hCAFE_BAFF);
`else
    expectVal("pre-edge masked r4", SEL_RD2, 32'hCAFE_BABE);
`endif
    tick();
    RegWrite = 1'b0;
    expectVal("post-edge masked r4", SEL_RD2, 32'hCAFE_BAFF);
    tick();

    @(negedge Clock);
    #1;
    check("scoreboard drained", 32'(sbQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
